// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU encodings for the logic units and the sum stage
package alu_pkg;
  typedef enum logic [1:0] {
    CIN_ZERO  = 2'b00,
    CIN_ONE   = 2'b01,
    CIN_FLAG  = 2'b10,
    CIN_NFLAG = 2'b11
  } cin_mode_e;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOT  = 3'd3,
    OP_PASS = 3'd4,
    OP_ZERO = 3'd5
  } alu_op_e;
endpackage

// File: rtl/alu_result_queue.sv
// alu_result_queue: 2-entry result FIFO with a registered head
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             alu_clk,
  input  logic             alu_rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [1:0]       occupancy
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic wr_ptr, rd_ptr, rd_ptr_nxt, pop;
  logic [1:0] occ_nxt;
  assign pop = rd_en && occupancy != 2'd0;
  assign rd_ptr_nxt = rd_ptr ^ pop;
  assign occ_nxt = occupancy + 2'(wr_en) - 2'(pop);
  // storage needs no reset; validity is tracked by occupancy
  always_ff @(posedge alu_clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  // pointers, occupancy and the head register; a write landing on the new head bypasses storage
  always_ff @(posedge alu_clk) begin
    if (!alu_rst_n) begin
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      occupancy    <= 2'd0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= ~wr_ptr;
      rd_ptr       <= rd_ptr_nxt;
      occupancy    <= occ_nxt;
      result_valid <= occ_nxt != 2'd0;
      if (occ_nxt != 2'd0) result <= (wr_en && wr_ptr == rd_ptr_nxt) ? wr_data : mem[rd_ptr_nxt];
    end
  end
endmodule

// File: rtl/alu_sum_stage.sv
// alu_sum_stage: adds the two logic-unit terms, updates flags, queues results
module alu_sum_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             alu_clk,
  input  logic             alu_rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [1:0]       carry_mode,
  input  logic             flags_we,
  input  logic [WIDTH-1:0] lhs_term,
  input  logic [WIDTH-1:0] rhs_term,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);
  logic inflight_v, fwe_q, pop, cin;
  cin_mode_e mode_q;
  logic [3:0] flags, flags_nxt;
  logic [1:0] occ;
  logic [2:0] slots;
  logic [WIDTH:0] sum;
  assign pop = result_valid && result_ready;
  assign slots = 3'(occ) + 3'(inflight_v) - 3'(pop);
  assign issue_ready = alu_rst_n && slots < 3'd2;
  assign sum = {1'b0, lhs_term} + {1'b0, rhs_term} + {{WIDTH{1'b0}}, cin};
  assign {flag_z, flag_c, flag_n, flag_v} = {flags[FLAG_Z], flags[FLAG_C], flags[FLAG_N], flags[FLAG_V]};
  // carry-in uses the live C flag so chained add-with-carry sees the previous op's update
  always_comb begin
    cin = mode_q == CIN_ONE ? 1'b1 : mode_q == CIN_FLAG ? flags[FLAG_C] : mode_q == CIN_NFLAG ? ~flags[FLAG_C] : 1'b0;
    flags_nxt = '0;
    flags_nxt[FLAG_Z] = sum[WIDTH-1:0] == '0;
    flags_nxt[FLAG_C] = sum[WIDTH];
    flags_nxt[FLAG_N] = sum[WIDTH-1];
    flags_nxt[FLAG_V] = lhs_term[WIDTH-1] == rhs_term[WIDTH-1] && sum[WIDTH-1] != lhs_term[WIDTH-1];
  end
  // in-flight stage and architectural flags
  always_ff @(posedge alu_clk) begin
    if (!alu_rst_n) begin
      inflight_v <= 1'b0;
      fwe_q      <= 1'b0;
      mode_q     <= CIN_ZERO;
      flags      <= '0;
    end else begin
      inflight_v <= issue_valid && issue_ready;
      if (issue_valid && issue_ready) begin
        mode_q <= cin_mode_e'(carry_mode);
        fwe_q  <= flags_we;
      end
      if (inflight_v && fwe_q) flags <= flags_nxt;
    end
  end
  // a capture must always find a free slot
  always_ff @(posedge alu_clk)
    if (alu_rst_n && inflight_v) assert (occ != 2'd2 || pop);
  alu_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_queue (
    .alu_clk     (alu_clk),
    .alu_rst_n   (alu_rst_n),
    .wr_en       (inflight_v),
    .wr_data     (sum[WIDTH-1:0]),
    .rd_en       (pop),
    .result      (result),
    .result_valid(result_valid),
    .occupancy   (occ)
  );
endmodule

// File: tb/tb_alu_sum_stage.sv
// tb_alu_sum_stage: directed self-checking bench for alu_sum_stage
module tb_alu_sum_stage;
  logic alu_clk = 1'b0, alu_rst_n, issue_valid, issue_ready, flags_we, result_valid, result_ready;
  logic flag_z, flag_c, flag_n, flag_v;
  logic [1:0] carry_mode;
  logic [7:0] lhs_term, rhs_term, result;
  int tests = 0, fails = 0;
  alu_sum_stage #(.WIDTH(8), .DEPTH(2)) dut (
    .alu_clk(alu_clk), .alu_rst_n(alu_rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .carry_mode(carry_mode), .flags_we(flags_we), .lhs_term(lhs_term), .rhs_term(rhs_term),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
  );
  always #5 alu_clk = ~alu_clk;
  task automatic tick();
    @(posedge alu_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] flg();
    return {flag_z, flag_c, flag_n, flag_v};
  endfunction
  logic [7:0] la [20], ra [20];
  logic [1:0] ma [20];
  logic wa [20];
  logic [3:0] mf;
  logic [8:0] s;
  logic mc;
  initial begin
    alu_rst_n = 1'b0; issue_valid = 1'b0; carry_mode = 2'd0; flags_we = 1'b0;
    lhs_term = 8'h00; rhs_term = 8'h00; result_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", 32'(flg()), 0);
    chk("rst_issue_ready", 32'(issue_ready), 0);
    alu_rst_n = 1'b1; #1;
    chk("post_rst_ready", 32'(issue_ready), 1);
    // 0x7F + 0x01 -> 0x80 with N and V
    issue_valid = 1'b1; carry_mode = 2'b00; flags_we = 1'b1;
    tick();
    issue_valid = 1'b0; lhs_term = 8'h7F; rhs_term = 8'h01;
    tick();
    chk("t2_result", 32'(result), 32'h80);
    chk("t2_valid", 32'(result_valid), 1);
    chk("t2_flags", 32'(flg()), 32'b0011);
    // 0xFF + 0x01 then back-to-back 0 + 0 + C
    issue_valid = 1'b1; carry_mode = 2'b00; flags_we = 1'b1;
    tick();
    carry_mode = 2'b10; lhs_term = 8'hFF; rhs_term = 8'h01;
    tick();
    chk("t3a_result", 32'(result), 32'h00);
    chk("t3a_flags", 32'(flg()), 32'b1100);
    issue_valid = 1'b0; lhs_term = 8'h00; rhs_term = 8'h00;
    tick();
    chk("t3b_result", 32'(result), 32'h01);
    chk("t3b_valid", 32'(result_valid), 1);
    chk("t3b_flags", 32'(flg()), 32'b0000);
    // set C=1, Z=0, then a non-flag op with cin=~C
    issue_valid = 1'b1; carry_mode = 2'b00; flags_we = 1'b1;
    tick();
    issue_valid = 1'b0; lhs_term = 8'hFF; rhs_term = 8'h02;
    tick();
    chk("t5a_result", 32'(result), 32'h01);
    chk("t5a_flags", 32'(flg()), 32'b0100);
    issue_valid = 1'b1; carry_mode = 2'b11; flags_we = 1'b0;
    tick();
    issue_valid = 1'b0; lhs_term = 8'h00; rhs_term = 8'h00;
    tick();
    chk("t5b_result", 32'(result), 32'h00);
    chk("t5b_valid", 32'(result_valid), 1);
    chk("t5b_flags", 32'(flg()), 32'b0100);
    tick();
    chk("empty_valid", 32'(result_valid), 0);
    chk("empty_hold", 32'(result), 32'h00);
    // backpressure: three issues with consumer stalled
    result_ready = 1'b0; issue_valid = 1'b1; carry_mode = 2'b00; flags_we = 1'b1;
    tick();
    chk("t4_ready1", 32'(issue_ready), 1);
    lhs_term = 8'h10; rhs_term = 8'h01;
    tick();
    chk("t4_ready2", 32'(issue_ready), 0);
    lhs_term = 8'h20; rhs_term = 8'h02;
    tick();
    chk("t4_stall_ready", 32'(issue_ready), 0);
    chk("t4_head_a", 32'(result), 32'h11);
    tick();
    chk("t4_still_stalled", 32'(issue_ready), 0);
    chk("t4_head_hold", 32'(result), 32'h11);
    result_ready = 1'b1; #1;
    chk("t4_pop_frees", 32'(issue_ready), 1);
    tick();
    chk("t4_head_b", 32'(result), 32'h22);
    issue_valid = 1'b0; lhs_term = 8'h30; rhs_term = 8'h03;
    tick();
    chk("t4_head_c", 32'(result), 32'h33);
    chk("t4_valid_c", 32'(result_valid), 1);
    tick();
    chk("t4_drained", 32'(result_valid), 0);
    // fill the queue, then reset mid-stream for 3 cycles
    result_ready = 1'b0; issue_valid = 1'b1;
    tick();
    lhs_term = 8'h01; rhs_term = 8'h01;
    tick();
    issue_valid = 1'b0; lhs_term = 8'h02; rhs_term = 8'h02;
    tick();
    chk("t1_full_head", 32'(result), 32'h02);
    chk("t1_full_ready", 32'(issue_ready), 0);
    alu_rst_n = 1'b0;
    tick(); tick(); tick();
    chk("t1_rst_ready", 32'(issue_ready), 0);
    alu_rst_n = 1'b1; #1;
    chk("t1_valid", 32'(result_valid), 0);
    chk("t1_result", 32'(result), 0);
    chk("t1_flags", 32'(flg()), 0);
    chk("t1_ready", 32'(issue_ready), 1);
    tick();
    chk("t1_no_ghost", 32'(result_valid), 0);
    // streaming: one op per cycle, reference sums computed here
    result_ready = 1'b1; mf = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      la[i] = 8'($urandom); ra[i] = 8'($urandom);
      ma[i] = 2'($urandom_range(3)); wa[i] = 1'($urandom_range(1));
    end
    issue_valid = 1'b1; carry_mode = ma[0]; flags_we = wa[0]; #1;
    chk("t6_ready0", 32'(issue_ready), 1);
    tick();
    for (int k = 1; k <= 20; k++) begin
      if (k < 20) begin
        carry_mode = ma[k]; flags_we = wa[k];
      end else issue_valid = 1'b0;
      lhs_term = la[k-1]; rhs_term = ra[k-1]; #1;
      if (k < 20) chk("t6_ready", 32'(issue_ready), 1);
      mc = ma[k-1] == 2'd0 ? 1'b0 : ma[k-1] == 2'd1 ? 1'b1 : ma[k-1] == 2'd2 ? mf[2] : ~mf[2];
      s = {1'b0, la[k-1]} + {1'b0, ra[k-1]} + {8'd0, mc};
      if (wa[k-1]) mf = {s[7:0] == 8'd0, s[8], s[7], la[k-1][7] == ra[k-1][7] && s[7] != la[k-1][7]};
      tick();
      chk("t6_result", 32'(result), 32'(s[7:0]));
      chk("t6_valid", 32'(result_valid), 1);
      chk("t6_flags", 32'(flg()), 32'(mf));
    end
    tick();
    chk("t6_drained", 32'(result_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_sum_stage.md
Name: alu_sum_stage

Overview:
Downstream stage of the two ALU logic units (lhs and rhs). Each logic unit registers its function output one alu_clk after an issue. This block captures both terms on that cycle, adds them with a selectable carry-in, and updates the Z/C/N/V flags. Results go into a 2-entry output queue with a valid/ready handshake toward the bus/register file. The block also drives issue_ready back to the ALU sequencer so that no term is ever dropped.

Parameters:
WIDTH, 8, datapath width of the terms and the result.
DEPTH, 2, output queue entries (fixed at 2; other values unsupported).

Ports:
alu_clk  in  1  ALU clock, all logic on rising edge.
alu_rst_n  in  1  synchronous, active-low reset.
issue_valid  in  1  operation/operands presented to the logic units this cycle.
issue_ready  out  1  issue is permitted this cycle.
carry_mode  in  2  sampled with issue: 00 cin=0, 01 cin=1, 10 cin=flag_c, 11 cin=~flag_c.
flags_we  in  1  sampled with issue: this op updates flags.
lhs_term  in  WIDTH  registered lhs logic-unit output.
rhs_term  in  WIDTH  registered rhs logic-unit output.
result  out  WIDTH  head-of-queue sum.
result_valid  out  1  queue non-empty.
result_ready  in  1  consumer accepts head.
flag_z, flag_c, flag_n, flag_v  out  1 each  architectural flags.

Behaviour:
- Reset is synchronous, active-low, on alu_clk. While alu_rst_n=0 at an edge:
  - in-flight stage, queue and pointers are cleared;
  - result=0, result_valid=0, all flags=0;
  - issue_ready=0 during reset, and 1 on the first cycle after release.
  - Reset mid-operation discards in-flight and queued ops with no flag update.
- Issue accepted when issue_valid && issue_ready at edge N. carry_mode and flags_we are latched into the in-flight stage (inflight_v=1).
- Capture at edge N+1: terms are unconditionally sampled while inflight_v=1 (the logic units have no stall).
  - sum = lhs_term + rhs_term + cin in WIDTH+1 bits. Entry written = sum[WIDTH-1:0].
  - cin is taken from flag_c as it stands at edge N+1, including an update made at edge N by the previous op. This gives correct back-to-back add-with-carry chains.
- Flag update at capture, only if the latched flags_we=1; otherwise flags hold:
  - Z = (sum[WIDTH-1:0]==0)
  - C = sum[WIDTH]
  - N = sum[WIDTH-1]
  - V = (lhs msb==rhs msb) && (sum msb != lhs msb)
- Latency: issue at edge N, result_valid=1 after edge N+1. The earliest accept is at edge N+2.
- Queue:
  - 2 entries; write pointer, read pointer and occupancy counter (0..2).
  - Pop when result_valid && result_ready. result/result_valid are registered from the head, with no combinational path from result_ready to result.
  - Simultaneous capture and pop: occupancy unchanged, order preserved, wrap-around via 1-bit pointers.
- issue_ready = (occupancy + inflight_v) < 2, with a pop this cycle counted as freeing a slot:
  - it is the only combinational path from result_ready;
  - this guarantees a slot for every capture. Overflow is impossible by construction.
  - An assertion fires if a capture finds the queue full.
- Empty queue: result holds its last value, result_valid=0. Popping when empty is ignored.
- The block is transparent to the logic-unit operation code; it sees only the terms.

Decomposition:
- Shared package alu_pkg holds:
  - the carry_mode encodings (CIN_ZERO, CIN_ONE, CIN_FLAG, CIN_NFLAG);
  - the flag bit indices;
  - the ALU operation codes already used by the logic units.
- One natural sub-module, alu_result_queue: 2-entry FIFO with pointers, occupancy and registered head.
- Adder and flag logic stay in alu_sum_stage.

Test Plan:
1. Reset held 3 cycles mid-stream with 2 queued results -> result_valid=0, flags all 0, result=0; issue_ready=1 on the first post-reset cycle.
2. Issue with carry_mode=00, flags_we=1; terms 0x7F, 0x01 -> after N+1, result=0x80, result_valid=1, Z=0, C=0, N=1, V=1.
3. Terms 0xFF, 0x01, mode 00, flags_we=1, then back-to-back issue with terms 0x00, 0x00, mode 10 -> first: result=0x00, Z=1, C=1. Second: result=0x01, C=0, Z=0 (uses fresh C).
4. result_ready=0, issue 3 ops on consecutive cycles -> issue_ready drops after the 2nd issue and the 3rd waits. Then assert result_ready -> results pop in order. The 3rd issues the same cycle the first pop occurs.
5. flags_we=0 op with terms 0x00, 0x00 after flags Z=0, C=1 -> result=0x00, flags unchanged (Z=0, C=1).
6. Continuous issue with result_ready=1 for 20 ops of random terms and modes -> throughput 1/cycle, each result matches the reference sum, no assertion fires, and pointers wrap correctly.
